// File: rtl/invert_sq_root.sv
// ---------------------------------------------------------------------------
// invert_sq_root
//   Pipelined fast inverse square root for IEEE-754 single precision,
//   DataOut ~= 1/sqrt(DataIn). The 0x5F3759DF integer seed is refined by
//   Newton-Raphson steps built from a flush-to-zero, round-to-nearest-even
//   float multiplier and subtractor, so results are bit-exact with a C float
//   model that rounds every operation.
//
//   Optional build macro: INVSQRT_SECOND_ITER_EN
//     undefined : one Newton step, 5-cycle latency
//     defined   : two Newton steps, 8-cycle latency
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ce         clock enable; 0 freezes every register
//   DataIn     [31:0] IEEE-754 single input sample
//   DataOut    [31:0] IEEE-754 single result (registered)
//   DataValid  DataOut carries a new result this cycle (gated by ce)
// ---------------------------------------------------------------------------
module invert_sq_root #(
  parameter logic [31:0] MAGIC   = 32'h5F3759DF,
`ifdef INVSQRT_SECOND_ITER_EN
  parameter int          LATENCY = 8
`else
  parameter int          LATENCY = 5
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        DataValid
);

  localparam logic [31:0] ONE_P5 = 32'h3FC00000;

  // Round a normalised 24-bit mantissa (hidden bit at [23]) with guard and
  // sticky, then pack. Exponent range is checked after rounding so a carry
  // out of the mantissa can lift a value out of the underflow region.
  function automatic logic [31:0] round_pack(input logic sgn,
                                             input logic signed [10:0] e_in,
                                             input logic [23:0] mant_in,
                                             input logic g,
                                             input logic st);
    logic signed [10:0] e;
    logic [24:0]        mr;
    logic [23:0]        mant;
    e  = e_in;
    mr = {1'b0, mant_in} + {24'd0, (g & (st | mant_in[0]))};
    if (mr[24]) begin
      e    = e + 11'sd1;
      mant = mr[24:1];
    end else begin
      mant = mr[23:0];
    end
    if (e <= 11'sd0)
      round_pack = 32'h0000_0000;
    else if (e >= 11'sd255)
      round_pack = {sgn, 8'hFF, 23'd0};
    else
      round_pack = {sgn, e[7:0], mant[22:0]};
  endfunction

  // Float multiply: exact 48-bit product, RNE. A zero-exponent operand is
  // treated as zero and gives +0.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [23:0]        ma, mb, mant;
    logic [47:0]        prod;
    logic signed [10:0] e;
    logic               g, st;
    sgn  = a[31] ^ b[31];
    ma   = {1'b1, a[22:0]};
    mb   = {1'b1, b[22:0]};
    prod = ma * mb;
    e    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (prod[47]) begin
      mant = prod[47:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 11'sd1;
    end else begin
      mant = prod[46:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      fmul = 32'h0000_0000;
    else
      fmul = round_pack(sgn, e, mant, g, st);
  endfunction

  // Float subtract a - b. The smaller magnitude is aligned into a field with
  // 27 spare low bits, the lowest holding the sticky of everything shifted
  // out; that keeps guard/round exact through the at-most-one-bit
  // cancellation that can occur once the operands are two or more apart.
  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        bn, x, y;
    logic [7:0]         d;
    logic [51:0]        fx, fyf, fy, sum, norm;
    logic [5:0]         p;
    logic signed [10:0] e;
    bn = b ^ 32'h8000_0000;
    if (a[30:0] >= bn[30:0]) begin
      x = a;
      y = bn;
    end else begin
      x = bn;
      y = a;
    end
    d   = x[30:23] - y[30:23];
    fx  = {2'b01, x[22:0], 27'd0};
    fyf = {2'b01, y[22:0], 27'd0};
    fy  = (fyf >> d) | {51'd0, ((fyf & ((52'd1 << d) - 52'd1)) != 52'd0)};
    if (x[31] == y[31])
      sum = fx + fy;
    else
      sum = fx - fy;
    p = 6'd0;
    for (int k = 0; k < 52; k++)
      if (sum[k]) p = 6'(k);
    norm = sum << (6'd51 - p);
    e    = $signed({3'b000, x[30:23]}) + $signed({5'b00000, p}) - 11'sd50;
    if (x[30:23] == 8'd0 || sum == 52'd0)
      fsub = 32'h0000_0000;
    else if (y[30:23] == 8'd0)
      fsub = x;
    else
      fsub = round_pack(x[31], e, norm[51:28], norm[27], |norm[26:0]);
  endfunction

  logic [31:0] w_y0, w_xh;
  logic [31:0] r_y0_p1, r_xh_p1;
  logic [31:0] r_s_p2, r_y0_p2, r_xh_p2;
  logic [31:0] r_t_p3, r_y0_p3;
  logic [31:0] r_r_p4, r_y0_p4;
  logic [31:0] r_out;
  logic [LATENCY-1:0] r_vld;

  // Seed and half-input; halving an input whose exponent is 0 or 1 would
  // leave the normal range, so it flushes to +0.
  assign w_y0 = MAGIC - {1'b0, DataIn[31:1]};
  assign w_xh = (DataIn[30:23] <= 8'd1) ? 32'h0000_0000
                                        : {DataIn[31], DataIn[30:23] - 8'd1, DataIn[22:0]};

  // The valid bit walks a shift register as long as the data pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_vld <= '0;
    else if (ce)
      r_vld <= {r_vld[LATENCY-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y0_p1 <= '0;
      r_xh_p1 <= '0;
      r_s_p2  <= '0;
      r_y0_p2 <= '0;
      r_xh_p2 <= '0;
      r_t_p3  <= '0;
      r_y0_p3 <= '0;
      r_r_p4  <= '0;
      r_y0_p4 <= '0;
    end else if (ce) begin
      // stage 1: seed and 0.5*x
      r_y0_p1 <= w_y0;
      r_xh_p1 <= w_xh;
      // stage 2: s = y0*y0
      r_s_p2  <= fmul(r_y0_p1, r_y0_p1);
      r_y0_p2 <= r_y0_p1;
      r_xh_p2 <= r_xh_p1;
      // stage 3: t = xh*s
      r_t_p3  <= fmul(r_xh_p2, r_s_p2);
      r_y0_p3 <= r_y0_p2;
      // stage 4: r = 1.5 - t
      r_r_p4  <= fsub(ONE_P5, r_t_p3);
      r_y0_p4 <= r_y0_p3;
    end
  end

`ifdef INVSQRT_SECOND_ITER_EN
  logic [31:0] r_xh_p3, r_xh_p4, r_xh_p5, r_xh_p6;
  logic [31:0] r_y1_p5, r_y1_p6, r_y1_p7;
  logic [31:0] r_s2_p6, r_t2_p7;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xh_p3 <= '0;
      r_xh_p4 <= '0;
      r_xh_p5 <= '0;
      r_xh_p6 <= '0;
      r_y1_p5 <= '0;
      r_y1_p6 <= '0;
      r_y1_p7 <= '0;
      r_s2_p6 <= '0;
      r_t2_p7 <= '0;
      r_out   <= '0;
    end else if (ce) begin
      r_xh_p3 <= r_xh_p2;
      r_xh_p4 <= r_xh_p3;
      // stage 5: y1 = y0*r
      r_y1_p5 <= fmul(r_y0_p4, r_r_p4);
      r_xh_p5 <= r_xh_p4;
      // stage 6: s2 = y1*y1
      r_s2_p6 <= fmul(r_y1_p5, r_y1_p5);
      r_y1_p6 <= r_y1_p5;
      r_xh_p6 <= r_xh_p5;
      // stage 7: t2 = xh*s2
      r_t2_p7 <= fmul(r_xh_p6, r_s2_p6);
      r_y1_p7 <= r_y1_p6;
      // stage 8: y2 = y1*(1.5 - t2)
      r_out   <= fmul(r_y1_p7, fsub(ONE_P5, r_t2_p7));
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_out <= '0;
    else if (ce)
      // stage 5: y1 = y0*r
      r_out <= fmul(r_y0_p4, r_r_p4);
  end
`endif

  assign DataOut   = r_out;
  // Gated by ce so a result held through a stall is reported only once.
  assign DataValid = r_vld[LATENCY-1] & ce;

endmodule

// File: tb/tb_invert_sq_root.sv
module tb_invert_sq_root;

`ifdef INVSQRT_SECOND_ITER_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 5;
`endif
  localparam logic [31:0] MAGIC = 32'h5F3759DF;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DataValid;

  invert_sq_root dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .DataValid(DataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    real         approx;
    real         tol;
  } vec_t;

  typedef struct {
    logic [31:0] exp_bits;
    logic [31:0] din;
    real         approx;
    real         tol;
    int          idx;
  } sb_t;

  int          n_chk;
  int          n_err;
  int          en_cnt;
  logic [31:0] last_out;
  sb_t         q[$];
  vec_t        tab[10];
  logic [31:0] rnd[1000];

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: float operands widened to double, where products
  // of two 24-bit mantissas and the 1.5-t difference are exact, then
  // rounded back to single with RNE, subnormals flushed to +0.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] b;
    logic [52:0] m;
    logic [24:0] mr;
    logic [23:0] top;
    int          e;
    b = $realtobits(x);
    if (b[62:52] == 11'd0) return 32'h0;
    e   = int'(b[62:52]) - 896;
    m   = {1'b1, b[51:0]};
    mr  = {1'b0, m[52:29]} + {24'd0, (m[28] & ((|m[27:0]) | m[29]))};
    if (mr[24]) begin
      e++;
      top = mr[24:1];
    end else begin
      top = mr[23:0];
    end
    if (e <= 0) return 32'h0;
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    return {b[63], e[7:0], top[22:0]};
  endfunction

  function automatic logic [31:0] newton(input logic [31:0] y, input logic [31:0] xh);
    logic [31:0] s, t, r;
    s = r2f(f2r(y) * f2r(y));
    t = r2f(f2r(xh) * f2r(s));
    r = r2f(1.5 - f2r(t));
    return r2f(f2r(y) * f2r(r));
  endfunction

  function automatic logic [31:0] gold(input logic [31:0] x);
    logic [31:0] y, xh;
    y  = MAGIC - {1'b0, x[31:1]};
    xh = (x[30:23] <= 8'd1) ? 32'h0 : (x - 32'h0080_0000);
    y  = newton(y, xh);
`ifdef INVSQRT_SECOND_ITER_EN
    y  = newton(y, xh);
`endif
    return y;
  endfunction

  // One clock: present a sample (or a stall), then check the outputs 1 ns
  // after the edge against the scoreboard.
  task automatic cycle(input logic [31:0] din, input logic c, input real approx,
                       input real tol);
    sb_t   e;
    real   v;
    DataIn = din;
    ce     = c;
    @(posedge clk);
    #1;
    if (c) begin
      en_cnt++;
      e.exp_bits = gold(din);
      e.din      = din;
      e.approx   = approx;
      e.tol      = tol;
      e.idx      = en_cnt;
      q.push_back(e);
    end else begin
      chk(DataValid == 1'b0, "stall_valid", {31'd0, DataValid}, 32'd0);
      chk(DataOut == last_out, "stall_hold", DataOut, last_out);
    end
    if (DataValid) begin
      chk(q.size() != 0, "spurious_valid", DataOut, 32'd0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(DataOut == e.exp_bits, "result", DataOut, e.exp_bits);
        chk(en_cnt - e.idx == LAT - 1, "latency", en_cnt - e.idx, LAT - 1);
        if (e.tol > 0.0) begin
          v = f2r(DataOut) - e.approx;
          if (v < 0.0) v = -v;
          chk(v < e.tol, "approx", DataOut, e.din);
        end
      end
    end
    last_out = DataOut;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    en_cnt   = 0;
    last_out = 32'h0;
    rst      = 1'b0;
    ce       = 1'b0;
    DataIn   = 32'h0;

`ifdef INVSQRT_SECOND_ITER_EN
    tab[0] = '{32'h3F800000, 1.0,       2.0e-5};
    tab[1] = '{32'h40800000, 0.5,       2.0e-5};
`else
    tab[0] = '{32'h3F800000, 0.9983065, 2.0e-5};
    tab[1] = '{32'h40800000, 0.4991533, 2.0e-5};
`endif
    tab[2] = '{32'h41800000, 0.25,      5.0e-4};
    tab[3] = '{32'h3E800000, 2.0,       4.0e-3};
    tab[4] = '{32'h40000000, 0.7071068, 1.5e-3};
    tab[5] = '{32'h42C80000, 0.1,       2.0e-4};
    tab[6] = '{32'h3C23D70A, 10.0,      2.0e-2};
    tab[7] = '{32'h00000000, 0.0,       0.0};
    tab[8] = '{32'h00800000, 0.0,       0.0};
    tab[9] = '{32'h7F7FFFFF, 0.0,       0.0};

    for (int i = 0; i < 1000; i++)
      rnd[i] = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk(DataValid == 1'b0, "reset_valid", {31'd0, DataValid}, 32'd0);
      chk(DataOut == 32'h0, "reset_out", DataOut, 32'h0);
    end
    rst = 1'b1;

    // Directed table; the first four edges are pipeline fill
    for (int i = 0; i < 10; i++) begin
      cycle(tab[i].din, 1'b1, tab[i].approx, tab[i].tol);
      if (i < LAT - 1) begin
        chk(DataValid == 1'b0, "fill_valid", {31'd0, DataValid}, 32'd0);
        chk(DataOut == 32'h0, "fill_out", DataOut, 32'h0);
      end
    end

    // Zero input must give a large finite value
    chk(gold(32'h0) != 32'h0 && gold(32'h0) < 32'h7F800000 && gold(32'h0) > 32'h5F000000,
        "zero_input_model", gold(32'h0), 32'h5F3759DF);

    // Random stream, ce held high
    for (int i = 0; i < 1000; i++)
      cycle(rnd[i], 1'b1, 0.0, 0.0);

    // Same stream with an 11-cycle stall before sample 400
    for (int i = 0; i < 1000; i++) begin
      if (i == 400)
        for (int k = 0; k < 11; k++)
          cycle(32'($urandom), 1'b0, 0.0, 0.0);
      cycle(rnd[i], 1'b1, 0.0, 0.0);
    end

    // Asynchronous reset between edges, mid-stream
    for (int i = 0; i < 3; i++)
      cycle(tab[i].din, 1'b1, tab[i].approx, tab[i].tol);
    #3;
    rst = 1'b0;
    #1;
    chk(DataValid == 1'b0, "async_rst_valid", {31'd0, DataValid}, 32'd0);
    chk(DataOut == 32'h0, "async_rst_out", DataOut, 32'h0);
    @(posedge clk);
    #1;
    chk(DataOut == 32'h0, "rst_hold_out", DataOut, 32'h0);
    rst = 1'b1;
    q.delete();
    last_out = 32'h0;
    for (int i = 0; i < 10; i++)
      cycle(tab[i].din, 1'b1, tab[i].approx, tab[i].tol);

    // Only the samples still inside the pipeline may remain outstanding
    chk(q.size() == LAT - 1, "outstanding", q.size(), LAT - 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/invert_sq_root.md
Name: invert_sq_root

Overview:
- Pipelined fast inverse square root for IEEE-754 single precision: DataOut ≈ 1/sqrt(DataIn).
- Uses the 0x5F3759DF magic-constant seed followed by one Newton-Raphson step.
- Results are bit-exact with the team's C float golden model, which uses round-to-nearest-even on every float operation.
- Sits in the numeric datapath; accepts one sample per enabled clock.

Parameters:
- MAGIC, 32'h5F3759DF, seed constant.
- LATENCY, 5, enabled-cycles from input sample to its DataOut/DataValid (fixed by the structure; informational only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ce  input  1  clock enable; 0 freezes the whole pipeline.
- DataIn  input  32  IEEE-754 single, sampled on every clk edge with ce=1.
- DataOut  output  32  IEEE-754 single result.
- DataValid  output  1  DataOut holds a valid result for this cycle.

Behaviour:
- Reset (rst=0, async): all pipeline data registers, valid flags, DataOut and DataValid clear to 0. Release is synchronous to the next clk edge.
- Stage 1:
  - i = MAGIC − (DataIn >> 1) as a 32-bit integer.
  - xh = 0.5·DataIn, formed by exponent − 1; if exponent ≤ 1, xh = +0 (flush to zero).
  - A valid bit is set.
- Stage 2: s = y0·y0, where y0 is the float interpretation of i.
- Stage 3: t = xh·s.
- Stage 4: r = 1.5 − t.
- Stage 5: DataOut = y0·r, registered; DataValid = valid bit of stage 5.
- y0 and the valid bit travel alongside the data.
- Float multiply and subtract rules:
  - Full 24×24 mantissa product, round-to-nearest-even.
  - Subnormal results flushed to +0.
  - Exponent overflow saturates to ±Inf.
  - Subtract aligns exponents with guard/round/sticky bits and applies RNE.
- Latency: exactly 5 enabled clock edges. Throughput: 1 sample per enabled edge.
- ce=0:
  - No register updates; DataIn is ignored.
  - DataOut holds its last value.
  - DataValid is forced to 0 combinationally while ce=0, so stalled samples are never double-counted.
  - When ce returns to 1, the pipeline resumes with no sample lost or duplicated.
- Pipeline fill: the first 4 results after reset have DataValid=0 and DataOut=0.
- Domain: positive normal inputs are in the specified domain. Other inputs are passed through the same arithmetic with no special casing:
  - ±0 gives a large finite value.
  - Negative and NaN inputs give implementation-defined results; the bench masks these.
- Reset asserted mid-stream discards all in-flight samples immediately.

Optional Feature:
- Macro INVSQRT_SECOND_ITER_EN.
- When defined:
  - A second Newton step y2 = y1·(1.5 − xh·y1·y1) is appended as 3 more stages.
  - xh is delayed to match.
  - LATENCY becomes 8.
  - Golden model applies two iterations.
- When undefined: one iteration, LATENCY 5, as above.

Test Plan:
- Reset/fill: hold rst=0 for 3 cycles, release with ce=1, and stream samples.
  - DataValid=0 and DataOut=0 during reset and for the first 4 enabled edges.
  - First DataValid=1 on the 5th edge.
- DataIn=0x3F800000 (1.0):
  - Stage-1 seed i=0x3F7759DF.
  - DataOut ≈ 0.99831, bit-exact to the C model, 5 cycles later.
- DataIn=0x40800000 (4.0):
  - Seed 0x3EF759DF.
  - DataOut ≈ 0.49915, bit-exact to the C model.
- Stream 1000 random positive normal floats with ce=1 throughout.
  - 1000 valid outputs, in order, each with 0 difference from the C output.
- Same stream with ce=0 for samples 400–410.
  - DataValid=0 during the stall and DataOut frozen.
  - After the stall, outputs resume in order with no loss or duplication; all outputs match C.
- Assert rst=0 asynchronously mid-stream (between clock edges).
  - DataOut and DataValid go to 0 immediately.
  - After release, the next valid output appears exactly 5 enabled edges after the first new sample.
